// File: rtl/pixel_pkg.sv
// pixel_pkg: shared widths, limits, FSM states and request type for the pixel write master.
package pixel_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int X_MAX = 640;
  localparam int Y_MAX = 480;
  localparam int LINE_STRIDE = 640;
  typedef enum logic {ST_IDLE, ST_WRITE} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] color;
  } pix_req_t;
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base, input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
    return base + ADDR_W'(y) * ADDR_W'(LINE_STRIDE) + ADDR_W'(x);
  endfunction
endpackage

// File: rtl/pixel_avalon_write_master_fifo.sv
// pixel_req_fifo: show-ahead request FIFO with registered full/empty flags.
module pixel_req_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_push,
  input  pix_req_t i_data,
  input  logic     i_pop,
  output pix_req_t o_head,
  output logic     o_full,
  output logic     o_empty
);
  localparam int AW = $clog2(DEPTH);
  pix_req_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt, w_cnt;
  logic w_push, w_pop;
  assign w_push = i_push & !o_full;
  assign w_pop = i_pop & !o_empty;
  assign w_cnt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign o_head = r_mem[r_rd];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      o_full <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= w_cnt;
      o_full <= w_cnt == (AW+1)'(DEPTH);
      o_empty <= w_cnt == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/pixel_avalon_write_master.sv
// pixel_avalon_write_master: turns pixel requests into single-beat Avalon-MM frame buffer writes.
module pixel_avalon_write_master
  import pixel_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  input  logic [X_W-1:0]    i_pix_x,
  input  logic [Y_W-1:0]    i_pix_y,
  input  logic [DATA_W-1:0] i_pix_color,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic              o_avm_write,
  output logic [DATA_W-1:0] o_avm_writedata,
  input  logic              i_avm_waitrequest,
  output logic              o_busy,
  output logic [15:0]       o_done_count,
  output logic [15:0]       o_drop_count
);
  state_t r_state;
  logic r_live;
  pix_req_t w_head, w_req;
  logic w_full, w_empty, w_accept, w_in_range, w_done, w_pop;
  // r_live holds ready low until the first clock after reset release
  assign o_pix_ready = r_live & !w_full;
  assign w_accept = i_pix_valid & o_pix_ready;
  assign w_in_range = (i_pix_x < X_W'(X_MAX)) && (i_pix_y < Y_W'(Y_MAX));
  assign w_req = '{addr: pix_addr(BASE_ADDR, i_pix_y, i_pix_x), color: i_pix_color};
  assign w_done = o_avm_write & !i_avm_waitrequest;
  assign w_pop = !w_empty & ((r_state == ST_IDLE) | w_done);
  assign o_busy = !w_empty | o_avm_write;
  pixel_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_accept & w_in_range),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_live <= 1'b0;
      o_avm_address <= '0;
      o_avm_write <= 1'b0;
      o_avm_writedata <= '0;
      o_done_count <= '0;
      o_drop_count <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_done) o_done_count <= o_done_count + 1'b1;
      if (w_accept && !w_in_range && o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 1'b1;
      if (w_pop) begin
        o_avm_address <= w_head.addr;
        o_avm_writedata <= w_head.color;
        o_avm_write <= 1'b1;
        r_state <= ST_WRITE;
      end else if (w_done) begin
        o_avm_write <= 1'b0;
        r_state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pixel_avalon_write_master.sv
// tb_pixel_avalon_write_master: directed and random stimulus against a queue-plus-bus-slot reference model.
module tb_pixel_avalon_write_master;
  import pixel_pkg::*;
  logic clk = 1'b0, reset_n = 1'b1;
  logic i_pix_valid = 1'b0, o_pix_ready, i_avm_waitrequest = 1'b0;
  logic [X_W-1:0] i_pix_x = '0;
  logic [Y_W-1:0] i_pix_y = '0;
  logic [DATA_W-1:0] i_pix_color = '0;
  logic [ADDR_W-1:0] o_avm_address;
  logic o_avm_write, o_busy;
  logic [DATA_W-1:0] o_avm_writedata;
  logic [15:0] o_done_count, o_drop_count;
  always #5 clk = ~clk;
  pixel_avalon_write_master dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_pix_valid       (i_pix_valid),
    .o_pix_ready       (o_pix_ready),
    .i_pix_x           (i_pix_x),
    .i_pix_y           (i_pix_y),
    .i_pix_color       (i_pix_color),
    .o_avm_address     (o_avm_address),
    .o_avm_write       (o_avm_write),
    .o_avm_writedata   (o_avm_writedata),
    .i_avm_waitrequest (i_avm_waitrequest),
    .o_busy            (o_busy),
    .o_done_count      (o_done_count),
    .o_drop_count      (o_drop_count)
  );
  typedef struct {
    int unsigned addr;
    int unsigned color;
  } ent_t;
  ent_t pend_q[$];
  ent_t bus;
  bit bus_v, live;
  int exp_done, exp_drop;
  int vectors = 0, miscompares = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one clock: apply inputs, compare outputs with the model, advance the model
  task automatic cyc(input bit v, input int x, input int y, input int c, input bit w);
    bit acc, done;
    i_pix_valid = v;
    i_pix_x = X_W'(x);
    i_pix_y = Y_W'(y);
    i_pix_color = DATA_W'(c);
    i_avm_waitrequest = w;
    check("write", o_avm_write, bus_v);
    if (bus_v) begin
      check("addr", o_avm_address, bus.addr);
      check("data", o_avm_writedata, bus.color);
    end
    check("busy", o_busy, bus_v || pend_q.size() != 0);
    check("ready", o_pix_ready, live && pend_q.size() < 4);
    check("done_cnt", o_done_count, exp_done);
    check("drop_cnt", o_drop_count, exp_drop);
    acc = v && live && pend_q.size() < 4;
    done = bus_v && !w;
    if (done) exp_done = (exp_done + 1) % 65536;
    if ((!bus_v || done) && pend_q.size() > 0) begin
      bus = pend_q.pop_front();
      bus_v = 1;
    end else if (done) bus_v = 0;
    if (acc) begin
      if (x < 640 && y < 480) pend_q.push_back('{y * 640 + x, c});
      else if (exp_drop < 65535) exp_drop++;
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    i_pix_valid = 0;
    i_avm_waitrequest = 0;
    #2 reset_n = 0;
    #1;
    check("rst_write", o_avm_write, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_pix_ready, 0);
    check("rst_done", o_done_count, 0);
    check("rst_drop", o_drop_count, 0);
    @(negedge clk);
    reset_n = 1;
    pend_q.delete();
    bus_v = 0;
    exp_done = 0;
    exp_drop = 0;
    live = 1;
    @(negedge clk);
  endtask
  initial begin
    do_reset();
    cyc(1, 5, 2, 'hA5, 0);
    idle(4);
    check("t1_done", o_done_count, 1);
    for (int i = 0; i < 4; i++) cyc(1, i, 10, 16 + i, 0);
    idle(6);
    cyc(1, 1, 1, 1, 1);
    for (int i = 0; i < 6; i++) cyc(1, 20 + i, 3, 40 + i, 1);
    idle(10);
    do_reset();
    cyc(1, 640, 0, 1, 0);
    cyc(1, 0, 480, 2, 0);
    cyc(1, 639, 479, 'h3C, 0);
    idle(5);
    check("t4_drop", o_drop_count, 2);
    check("t4_done", o_done_count, 1);
    for (int i = 0; i < 4; i++) cyc(1, i, i, i, 1);
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 700), $urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 9) < 3);
    idle(10);
    for (int i = 0; i < 65600; i++) cyc(1, 640, 0, 0, 0);
    check("t6_sat", o_drop_count, 16'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
